// File: rtl/i2c_reg_scheduler_pkg.sv
// Shared types for the rover I2C register scheduler.
package roversPackage;
  typedef logic [7:0] bus08_t;
  typedef enum logic {IDLE, ISSUE} cmd_state_t;
endpackage

// File: rtl/i2c_reg_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);
  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end
endmodule

// File: rtl/i2c_reg_scheduler.sv
// Syncs master-written registers into clk, dispatches changed bytes as commands,
// and arbitrates status producers into the master-visible read bank.
module i2c_reg_scheduler
  import roversPackage::*;
#(
  parameter logic [7:0] HI_WR      = 8'h0F,
  parameter logic [7:0] HI_RD      = 8'h0F,
  parameter int         NUM_SRC    = 4,
  parameter int         STABLE_CYC = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [HI_WR:0][7:0]           wr_regs_i,
  output logic [HI_RD:0][7:0]           rd_regs_o,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output bus08_t                        cmd_idx,
  output bus08_t                        cmd_data,
  input  logic [NUM_SRC-1:0]            sts_valid,
  input  logic [NUM_SRC-1:0][7:0]       sts_idx,
  input  logic [NUM_SRC-1:0][7:0]       sts_data,
  output logic [NUM_SRC-1:0]            sts_ready,
  output logic                          sts_err
);
  localparam int         NW = int'(HI_WR) + 1;
  localparam int         WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int         SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [3:0] SC = 4'(STABLE_CYC);

  cmd_state_t            r_state, w_state_n;
  logic [NW-1:0][7:0]    w_stable, r_shadow;
  logic [NW-1:0]         w_pend, w_cgnt;
  logic [WW-1:0]         r_ptr, w_cidx, w_cur;
  logic                  w_cany, w_sany;
  bus08_t                w_cdata, w_sel_idx, w_sel_data;
  logic [SW-1:0]         r_sptr, w_sidx;

  assign w_cur = cmd_idx[WW-1:0];

  for (genvar g = 0; g < NW; g++) begin : g_in
    bus08_t     r_s1, r_s2, r_samp, r_stab;
    logic [3:0] r_cnt;
    // Counter restarts whenever the synced byte moves; stable only follows a settled value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1 <= '0; r_s2 <= '0; r_samp <= '0; r_stab <= '0; r_cnt <= '0;
      end else begin
        r_s1 <= wr_regs_i[g];
        r_s2 <= r_s1;
        if (r_s2 != r_samp) begin
          r_samp <= r_s2;
          r_cnt  <= 4'd1;
          if (SC == 4'd1) r_stab <= r_s2;
        end else if (r_cnt < SC) begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt + 4'd1 == SC) r_stab <= r_s2;
        end
      end
    end
    assign w_stable[g] = r_stab;
    assign w_pend[g]   = (r_stab != r_shadow[g]) && !(r_state == ISSUE && cmd_idx == 8'(g));
  end

  rr_arbiter #(.N(NW), .PW(WW)) u_cmd_arb (
    .req(w_pend), .ptr(r_ptr), .gnt(w_cgnt), .gnt_idx(w_cidx), .any(w_cany)
  );

  always_comb begin
    w_cdata = '0;
    for (int i = 0; i < NW; i++) if (w_cgnt[i]) w_cdata = w_cdata | w_stable[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (w_cany) w_state_n = ISSUE;
      ISSUE:   if (cmd_valid && cmd_ready) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_idx   <= '0;
      cmd_data  <= '0;
      r_shadow  <= '0;
      r_ptr     <= '0;
    end else if (r_state == IDLE && w_cany) begin
      cmd_valid <= 1'b1;
      cmd_idx   <= 8'(w_cidx);
      cmd_data  <= w_cdata;
    end else if (r_state == ISSUE && cmd_valid && cmd_ready) begin
      cmd_valid       <= 1'b0;
      r_shadow[w_cur] <= cmd_data;
      r_ptr           <= (w_cur == WW'(HI_WR)) ? '0 : w_cur + 1'b1;
    end
  end

  rr_arbiter #(.N(NUM_SRC), .PW(SW)) u_sts_arb (
    .req(sts_valid), .ptr(r_sptr), .gnt(sts_ready), .gnt_idx(w_sidx), .any(w_sany)
  );

  assign w_sel_idx  = sts_idx[w_sidx];
  assign w_sel_data = sts_data[w_sidx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_regs_o <= '0;
      sts_err   <= 1'b0;
      r_sptr    <= '0;
    end else if (w_sany) begin
      r_sptr <= (int'(w_sidx) == NUM_SRC - 1) ? '0 : w_sidx + 1'b1;
      if (w_sel_idx <= HI_RD) begin
        for (int j = 0; j <= int'(HI_RD); j++)
          if (w_sel_idx == 8'(j)) rd_regs_o[j] <= w_sel_data;
      end else begin
        sts_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_i2c_reg_scheduler.sv
// Randomized bench for i2c_reg_scheduler with a register-level reference model.
module tb_i2c_reg_scheduler;
  localparam logic [7:0] HI_WR = 8'h0F;
  localparam logic [7:0] HI_RD = 8'h0F;
  localparam int NUM_SRC = 4, STABLE_CYC = 2, NW = 16, NR = 16;

  logic clk = 1'b0, rst;
  logic [NW-1:0][7:0] wr_regs_i;
  logic [NR-1:0][7:0] rd_regs_o;
  logic cmd_valid, cmd_ready, sts_err;
  logic [7:0] cmd_idx, cmd_data;
  logic [NUM_SRC-1:0] sts_valid, sts_ready;
  logic [NUM_SRC-1:0][7:0] sts_idx, sts_data;

  i2c_reg_scheduler #(.HI_WR(HI_WR), .HI_RD(HI_RD), .NUM_SRC(NUM_SRC), .STABLE_CYC(STABLE_CYC)) dut (
    .clk(clk), .rst(rst), .wr_regs_i(wr_regs_i), .rd_regs_o(rd_regs_o),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
    .sts_valid(sts_valid), .sts_idx(sts_idx), .sts_data(sts_data), .sts_ready(sts_ready),
    .sts_err(sts_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] m_wr [NW];
  logic [7:0] m_sh [NW];
  logic [7:0] m_rd [NR];
  int   m_ptr, m_sptr;
  logic m_err;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_wr(input int i, input logic [7:0] v);
    m_wr[i] = v;
    wr_regs_i[i] = v;
  endtask

  task automatic model_reset;
    for (int i = 0; i < NW; i++) m_sh[i] = 8'h00;
    for (int i = 0; i < NR; i++) m_rd[i] = 8'h00;
    m_ptr = 0; m_sptr = 0; m_err = 1'b0;
  endtask

  // Next register the master's view says is out of date, scanning from the rr pointer.
  function automatic int model_next_cmd();
    for (int k = 0; k < NW; k++) begin
      int j = (m_ptr + k) % NW;
      if (m_wr[j] !== m_sh[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0][7:0] model_rd_bank();
    logic [NR-1:0][7:0] b;
    for (int i = 0; i < NR; i++) b[i] = m_rd[i];
    return b;
  endfunction

  task automatic run_cmds(input int cycles, input int ready_pct, input string tag);
    bit pv = 0, pr = 0, pacc = 0;
    logic [7:0] pidx = '0, pdata = '0;
    int e;
    for (int c = 0; c < cycles; c++) begin
      if (pacc) begin
        n_cmp++;
        if (cmd_valid !== 1'b0) begin
          n_bad++; $display("FAIL %s_dead_cycle: cmd_valid=%b required 0", tag, cmd_valid);
        end
      end
      if (pv && !pr) begin
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_idx !== pidx || cmd_data !== pdata) begin
          n_bad++;
          $display("FAIL %s_hold: valid=%b idx=%h data=%h required 1/%h/%h",
                   tag, cmd_valid, cmd_idx, cmd_data, pidx, pdata);
        end
      end
      cmd_ready = ($urandom_range(99) < ready_pct);
      if (cmd_valid === 1'b1) begin
        e = model_next_cmd();
        n_cmp++;
        if (e < 0) begin
          n_bad++; $display("FAIL %s_spurious: idx=%h data=%h required no command", tag, cmd_idx, cmd_data);
        end else if (cmd_idx !== 8'(e) || cmd_data !== m_wr[e]) begin
          n_bad++;
          $display("FAIL %s_cmd: idx=%h data=%h required %h/%h", tag, cmd_idx, cmd_data, 8'(e), m_wr[e]);
        end
        if (cmd_ready && e >= 0) begin
          m_sh[e] = m_wr[e];
          m_ptr = (e + 1) % NW;
        end
      end
      pv = cmd_valid; pr = cmd_ready; pidx = cmd_idx; pdata = cmd_data;
      pacc = cmd_valid && cmd_ready;
      tick;
    end
    n_cmp++;
    if (model_next_cmd() != -1 || cmd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_drain: pending_reg=%0d cmd_valid=%b required -1/0", tag, model_next_cmd(), cmd_valid);
    end
  endtask

  task automatic sts_cycle(input logic [NUM_SRC-1:0] v, input logic [NUM_SRC-1:0][7:0] ix,
                           input logic [NUM_SRC-1:0][7:0] dt, input string tag);
    int k = -1;
    logic [NUM_SRC-1:0] expg;
    n_cmp++;
    if (rd_regs_o !== model_rd_bank() || sts_err !== m_err) begin
      n_bad++;
      $display("FAIL %s_bank: rd=%h err=%b required %h/%b", tag, rd_regs_o, sts_err, model_rd_bank(), m_err);
    end
    sts_valid = v; sts_idx = ix; sts_data = dt;
    #1;
    for (int q = 0; q < NUM_SRC; q++) begin
      int j = (m_sptr + q) % NUM_SRC;
      if (k < 0 && v[j]) k = j;
    end
    expg = (k < 0) ? '0 : NUM_SRC'(1 << k);
    n_cmp++;
    if (sts_ready !== expg) begin
      n_bad++; $display("FAIL %s_grant: sts_ready=%b required %b", tag, sts_ready, expg);
    end
    if (k >= 0) begin
      if (ix[k] <= HI_RD) m_rd[ix[k]] = dt[k];
      else m_err = 1'b1;
      m_sptr = (k + 1) % NUM_SRC;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int c = 0; c < 20 && cmd_valid !== 1'b1; c++) tick;
    n_cmp++;
    if (cmd_valid !== 1'b1) begin
      n_bad++; $display("FAIL %s_timeout: cmd_valid=%b required 1 within 20 cycles", tag, cmd_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_ready = 1'b0; sts_valid = '0; sts_idx = '0; sts_data = '0;
    for (int i = 0; i < NW; i++) set_wr(i, 8'h00);
    model_reset();
    repeat (3) tick;
    n_cmp++;
    if (cmd_valid !== 1'b0 || cmd_idx !== 8'h00 || cmd_data !== 8'h00 || rd_regs_o !== '0 || sts_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b idx=%h data=%h rd=%h err=%b required all zero",
               cmd_valid, cmd_idx, cmd_data, rd_regs_o, sts_err);
    end
    rst = 1'b0;
    repeat (6) tick;
    n_cmp++;
    if (cmd_valid !== 1'b0 || sts_ready !== '0) begin
      n_bad++; $display("FAIL reset_idle: valid=%b sts_ready=%b required 0/0", cmd_valid, sts_ready);
    end
  endtask

  task automatic test_sts_all;
    logic [NUM_SRC-1:0][7:0] ix, dt;
    for (int k = 0; k < NUM_SRC; k++) begin ix[k] = 8'(k); dt[k] = 8'($urandom_range(1, 255)); end
    for (int c = 0; c < NUM_SRC; c++) sts_cycle(4'hF, ix, dt, "sts_all");
    sts_cycle(4'h0, ix, dt, "sts_all");
  endtask

  task automatic test_sts_err;
    logic [NUM_SRC-1:0][7:0] ix, dt;
    ix = '0; dt = '0; ix[1] = 8'h20; dt[1] = 8'h77;
    sts_cycle(4'b0010, ix, dt, "sts_err");
    for (int c = 0; c < 3; c++) sts_cycle(4'h0, ix, dt, "sts_err_sticky");
  endtask

  task automatic test_sts_random;
    logic [NUM_SRC-1:0][7:0] ix, dt;
    for (int c = 0; c < 150; c++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        ix[k] = 8'($urandom_range(0, 19)); dt[k] = 8'($urandom_range(0, 255));
      end
      sts_cycle(NUM_SRC'($urandom_range(0, 15)), ix, dt, "sts_rand");
    end
    sts_cycle(4'h0, ix, dt, "sts_rand");
  endtask

  task automatic test_single;
    int lat = 0;
    cmd_ready = 1'b1;
    set_wr(3, 8'hA5);
    while (cmd_valid !== 1'b1 && lat < 20) begin tick; lat++; end
    n_cmp++;
    if (lat < 2 + STABLE_CYC + 1 || lat > 2 + STABLE_CYC + 2) begin
      n_bad++; $display("FAIL single_latency: cycles=%0d required %0d..%0d", lat, 3 + STABLE_CYC, 4 + STABLE_CYC);
    end
    run_cmds(30, 100, "single");
  endtask

  task automatic test_multi;
    cmd_ready = 1'b1;
    set_wr(2, 8'h12); set_wr(5, 8'h55); set_wr(9, 8'h99);
    run_cmds(40, 100, "multi");
    set_wr(2, 8'h21);
    run_cmds(20, 100, "multi_rr");
  endtask

  task automatic test_inflight;
    logic [7:0] orig7;
    cmd_ready = 1'b0;
    set_wr(3, 8'h5A);
    wait_valid("inflight");
    orig7 = m_wr[7];
    for (int c = 0; c < 14; c++) begin
      if (c == 0) begin set_wr(3, 8'h3C); set_wr(7, 8'hEE); end
      if (c == 5) set_wr(7, orig7);
      n_cmp++;
      if (cmd_valid !== 1'b1 || cmd_idx !== 8'h03 || cmd_data !== 8'h5A) begin
        n_bad++;
        $display("FAIL inflight_hold: valid=%b idx=%h data=%h required 1/03/5a", cmd_valid, cmd_idx, cmd_data);
      end
      tick;
    end
    cmd_ready = 1'b1;
    tick;
    m_sh[3] = 8'h5A; m_ptr = 4;
    run_cmds(30, 100, "inflight_re");
  endtask

  task automatic test_cmd_random;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NW; i++)
        if ($urandom_range(99) < 30) set_wr(i, 8'($urandom_range(0, 255)));
      run_cmds(200, 60, "cmd_rand");
    end
  endtask

  task automatic test_rst_mid;
    cmd_ready = 1'b0;
    set_wr(3, (m_wr[3] == 8'hA5) ? 8'h5A : 8'hA5);
    wait_valid("rst_mid");
    rst = 1'b1;
    #1;
    n_cmp++;
    if (cmd_valid !== 1'b0 || rd_regs_o !== '0 || sts_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_async: valid=%b rd=%h err=%b required 0/0/0", cmd_valid, rd_regs_o, sts_err);
    end
    repeat (3) tick;
    model_reset();
    set_wr(3, 8'hA5);
    rst = 1'b0;
    cmd_ready = 1'b1;
    run_cmds(200, 100, "rst_redispatch");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sts_all();
    test_sts_err();
    test_sts_random();
    test_single();
    test_multi();
    test_inflight();
    test_cmd_random();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
